// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encodings,
// instruction classes, ALUOp encodings and opcode/func field values.
// Ports: none (package).
package multicycle_ctrl_pkg;

  // FSM state encodings (4-bit; unused encodings 10-15 recover to FETCH)
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC   = 4'd2;
  localparam logic [3:0] ST_WB     = 4'd3;
  localparam logic [3:0] ST_ADDR   = 4'd4;
  localparam logic [3:0] ST_MEM_RD = 4'd5;
  localparam logic [3:0] ST_MEM_WR = 4'd6;
  localparam logic [3:0] ST_LD_WB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;

  typedef enum logic [3:0] {
    CLS_NONE    = 4'd0,
    CLS_R_ALU   = 4'd1,
    CLS_R_SHIFT = 4'd2,
    CLS_I_ALU   = 4'd3,
    CLS_LW      = 4'd4,
    CLS_SW      = 4'd5,
    CLS_BEQ     = 4'd6,
    CLS_BNE     = 4'd7,
    CLS_J       = 4'd8,
    CLS_JAL     = 4'd9,
    CLS_JR      = 4'd10,
    CLS_ILLEGAL = 4'd11
  } cls_t;

  // ALUOp encodings shared with the single-cycle datapath
  localparam logic [4:0] ALUOp_ADD  = 5'd0;
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_SUB  = 5'd2;
  localparam logic [4:0] ALUOp_SUBU = 5'd3;
  localparam logic [4:0] ALUOp_AND  = 5'd4;
  localparam logic [4:0] ALUOp_OR   = 5'd5;
  localparam logic [4:0] ALUOp_XOR  = 5'd6;
  localparam logic [4:0] ALUOp_NOR  = 5'd7;
  localparam logic [4:0] ALUOp_SLT  = 5'd8;
  localparam logic [4:0] ALUOp_SLTU = 5'd9;
  localparam logic [4:0] ALUOp_SLL  = 5'd10;
  localparam logic [4:0] ALUOp_SRL  = 5'd11;
  localparam logic [4:0] ALUOp_SRA  = 5'd12;
  localparam logic [4:0] ALUOp_LUI  = 5'd13;
  localparam logic [4:0] ALUOp_EQL  = 5'd14;
  localparam logic [4:0] ALUOp_BNE  = 5'd15;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // R-type results go to rd; everything else writes rt (or $31 for jal)
  function automatic logic is_r_class(input cls_t cls);
    return (cls == CLS_R_ALU) || (cls == CLS_R_SHIFT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// mc_decode: combinational opcode/func -> instruction class and ALU controls.
// Ports: opcode[5:0], func[5:0] in; cls, alu_ctrl[4:0], alu_src, ext_op,
//        shamt_src out.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output cls_t       cls,
  output logic [4:0] alu_ctrl,
  output logic       alu_src,
  output logic       ext_op,
  output logic       shamt_src
);

  // instruction class and ALU controls, same mapping as the single-cycle decoder
  always_comb begin
    cls       = CLS_ILLEGAL;
    alu_ctrl  = ALUOp_ADD;
    alu_src   = 1'b0;
    ext_op    = 1'b0;
    shamt_src = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_R_ALU;
        case (func)
          FN_ADD:  alu_ctrl = ALUOp_ADD;
          FN_ADDU: alu_ctrl = ALUOp_ADDU;
          FN_SUB:  alu_ctrl = ALUOp_SUB;
          FN_SUBU: alu_ctrl = ALUOp_SUBU;
          FN_AND:  alu_ctrl = ALUOp_AND;
          FN_OR:   alu_ctrl = ALUOp_OR;
          FN_XOR:  alu_ctrl = ALUOp_XOR;
          FN_NOR:  alu_ctrl = ALUOp_NOR;
          FN_SLT:  alu_ctrl = ALUOp_SLT;
          FN_SLTU: alu_ctrl = ALUOp_SLTU;
          FN_SLL:  begin cls = CLS_R_SHIFT; alu_ctrl = ALUOp_SLL; shamt_src = 1'b1; end
          FN_SRL:  begin cls = CLS_R_SHIFT; alu_ctrl = ALUOp_SRL; shamt_src = 1'b1; end
          FN_SRA:  begin cls = CLS_R_SHIFT; alu_ctrl = ALUOp_SRA; shamt_src = 1'b1; end
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI: begin cls = CLS_I_ALU; alu_ctrl = ALUOp_ADD; alu_src = 1'b1; ext_op = 1'b1; end
      OP_SLTI: begin cls = CLS_I_ALU; alu_ctrl = ALUOp_SLT; alu_src = 1'b1; ext_op = 1'b1; end
      OP_ORI:  begin cls = CLS_I_ALU; alu_ctrl = ALUOp_OR;  alu_src = 1'b1; end
      OP_LUI:  begin cls = CLS_I_ALU; alu_ctrl = ALUOp_LUI; alu_src = 1'b1; end
      OP_LW:   begin cls = CLS_LW; alu_ctrl = ALUOp_ADD; alu_src = 1'b1; ext_op = 1'b1; end
      OP_SW:   begin cls = CLS_SW; alu_ctrl = ALUOp_ADD; alu_src = 1'b1; ext_op = 1'b1; end
      OP_BEQ:  begin cls = CLS_BEQ; alu_ctrl = ALUOp_EQL; end
      OP_BNE:  begin cls = CLS_BNE; alu_ctrl = ALUOp_BNE; end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style multicycle MIPS control FSM.
// Ports: clk, rst (sync, active-high), opcode[5:0], func[5:0], zero,
//        mem_ready in; datapath strobes/selects, ALUCtrl[4:0], state[3:0],
//        instr_done and illegal pulses out.
// Outputs are decoded from the current state (plus mem_ready/zero where a
// strobe is conditional) and forced to 0 while rst is high.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic       ShamtSrc,
  output logic       instr_done,
  output logic       illegal,
  output logic [1:0] RegDst,
  output logic [1:0] DatatoReg,
  output logic [1:0] PC_sel,
  output logic [4:0] ALUCtrl,
  output logic [3:0] state
);

  logic [3:0] state_r;
  logic [3:0] state_next;
  cls_t       cls_r;
  cls_t       dec_cls;
  logic [4:0] dec_alu_ctrl;
  logic       dec_alu_src;
  logic       dec_ext_op;
  logic       dec_shamt_src;

  // opcode/func stay valid in the external IR, so EXEC/WB reuse the live decode
  mc_decode u_decode (
    .opcode    (opcode),
    .func      (func),
    .cls       (dec_cls),
    .alu_ctrl  (dec_alu_ctrl),
    .alu_src   (dec_alu_src),
    .ext_op    (dec_ext_op),
    .shamt_src (dec_shamt_src)
  );

  // state register and instruction-class register (captured in DECODE)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
      cls_r   <= CLS_NONE;
    end else begin
      state_r <= state_next;
      if (state_r == ST_DECODE) cls_r <= dec_cls;
      else                      cls_r <= cls_r;
    end
  end

  // next-state and output decode
  always_comb begin
    state_next = ST_FETCH;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    ALUSrc     = 1'b0;
    ExtOp      = 1'b0;
    ShamtSrc   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    RegDst     = 2'b00;
    DatatoReg  = 2'b00;
    PC_sel     = 2'b00;
    ALUCtrl    = 5'd0;
    state      = 4'd0;
    if (rst) begin
      // any in-flight access is abandoned: every strobe stays low
      state_next = ST_FETCH;
    end else begin
      state = state_r;
      case (state_r)
        ST_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            state_next = ST_DECODE;
          end else begin
            state_next = ST_FETCH;
          end
        end
        ST_DECODE: begin
          case (dec_cls)
            CLS_R_ALU, CLS_R_SHIFT, CLS_I_ALU: state_next = ST_EXEC;
            CLS_LW, CLS_SW:                    state_next = ST_ADDR;
            CLS_BEQ, CLS_BNE:                  state_next = ST_BRANCH;
            CLS_J, CLS_JAL, CLS_JR:            state_next = ST_JUMP;
            default: begin
              illegal    = 1'b1;
              state_next = ST_FETCH;
            end
          endcase
        end
        ST_EXEC, ST_WB: begin
          ALUCtrl  = dec_alu_ctrl;
          ALUSrc   = dec_alu_src;
          ExtOp    = dec_ext_op;
          ShamtSrc = dec_shamt_src;
          if (state_r == ST_WB) begin
            RegWrite   = 1'b1;
            RegDst     = is_r_class(cls_r) ? 2'b01 : 2'b00;
            instr_done = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
        ST_ADDR: begin
          ALUSrc  = 1'b1;
          ExtOp   = 1'b1;
          ALUCtrl = ALUOp_ADD;
          if (cls_r == CLS_SW) state_next = ST_MEM_WR;
          else                 state_next = ST_MEM_RD;
        end
        ST_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_next = ST_LD_WB;
          else           state_next = ST_MEM_RD;
        end
        ST_LD_WB: begin
          RegWrite   = 1'b1;
          DatatoReg  = 2'b01;
          instr_done = 1'b1;
          state_next = ST_FETCH;
        end
        ST_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_MEM_WR;
          end
        end
        ST_BRANCH: begin
          ALUCtrl    = (cls_r == CLS_BNE) ? ALUOp_BNE : ALUOp_EQL;
          PC_sel     = 2'b01;
          PCWrite    = zero;
          instr_done = 1'b1;
          state_next = ST_FETCH;
        end
        ST_JUMP: begin
          PCWrite    = 1'b1;
          instr_done = 1'b1;
          PC_sel     = (cls_r == CLS_JR) ? 2'b11 : 2'b10;
          if (cls_r == CLS_JAL) begin
            RegWrite  = 1'b1;
            RegDst    = 2'b10;
            DatatoReg = 2'b10;
          end else begin
            RegWrite  = 1'b0;
          end
          state_next = ST_FETCH;
        end
        default: state_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences
// with hand-computed per-cycle expected output vectors.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] opcode, func;
  logic IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrc, ExtOp;
  logic ShamtSrc, instr_done, illegal;
  logic [1:0] RegDst, DatatoReg, PC_sel;
  logic [4:0] ALUCtrl;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ShamtSrc(ShamtSrc),
    .instr_done(instr_done), .illegal(illegal), .RegDst(RegDst),
    .DatatoReg(DatatoReg), .PC_sel(PC_sel), .ALUCtrl(ALUCtrl), .state(state)
  );

  // flag order: IRWrite PCWrite RegWrite MemRead MemWrite IorD ALUSrc ExtOp ShamtSrc instr_done illegal
  wire [25:0] obs = {state, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IorD,
                     ALUSrc, ExtOp, ShamtSrc, instr_done, illegal,
                     RegDst, DatatoReg, PC_sel, ALUCtrl};

  function automatic logic [25:0] ev(input logic [3:0] st, input logic [10:0] fl,
                                     input logic [1:0] rd, input logic [1:0] dr,
                                     input logic [1:0] pc, input logic [4:0] alu);
    return {st, fl, rd, dr, pc, alu};
  endfunction

  localparam logic [10:0] F_FETCH = 11'b11010000000;

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00; func = 6'h00; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 26'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: got %h expected %h", i, obs, 26'd0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_addu();
    logic [25:0] exp_v [4];
    opcode = OP_RTYPE; func = FN_ADDU; mem_ready = 1'b1;
    exp_v[0] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[1] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[2] = ev(4'd2, 11'd0, 2'b00, 2'b00, 2'b00, ALUOp_ADDU);
    exp_v[3] = ev(4'd3, 11'b00100000010, 2'b01, 2'b00, 2'b00, ALUOp_ADDU);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL addu cyc%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sll_ori();
    logic [25:0] exp_v [8];
    exp_v[0] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[1] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[2] = ev(4'd2, 11'b00000000100, 2'b00, 2'b00, 2'b00, ALUOp_SLL);
    exp_v[3] = ev(4'd3, 11'b00100000110, 2'b01, 2'b00, 2'b00, ALUOp_SLL);
    exp_v[4] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[5] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[6] = ev(4'd2, 11'b00000010000, 2'b00, 2'b00, 2'b00, ALUOp_OR);
    exp_v[7] = ev(4'd3, 11'b00100010010, 2'b00, 2'b00, 2'b00, ALUOp_OR);
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin opcode = OP_RTYPE; func = FN_SLL; end
      else       begin opcode = OP_ORI;   func = 6'h3F;  end
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL sll_ori cyc%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [25:0] exp_v [8];
    logic        mr_v  [8];
    opcode = OP_LW; func = 6'h00;
    exp_v[0] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);              mr_v[0] = 1'b1;
    exp_v[1] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);                mr_v[1] = 1'b1;
    exp_v[2] = ev(4'd4, 11'b00000011000, 2'b00, 2'b00, 2'b00, ALUOp_ADD); mr_v[2] = 1'b1;
    exp_v[3] = ev(4'd5, 11'b00010100000, 2'b00, 2'b00, 2'b00, 5'd0);      mr_v[3] = 1'b0;
    exp_v[4] = ev(4'd5, 11'b00010100000, 2'b00, 2'b00, 2'b00, 5'd0);      mr_v[4] = 1'b0;
    exp_v[5] = ev(4'd5, 11'b00010100000, 2'b00, 2'b00, 2'b00, 5'd0);      mr_v[5] = 1'b1;
    exp_v[6] = ev(4'd7, 11'b00100000010, 2'b00, 2'b01, 2'b00, 5'd0);      mr_v[6] = 1'b1;
    exp_v[7] = ev(4'd0, 11'b00010000000, 2'b00, 2'b00, 2'b00, 5'd0);      mr_v[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr_v[i];
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL lw_wait cyc%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [25:0] exp_v [4];
    opcode = OP_SW; func = 6'h00; mem_ready = 1'b1;
    exp_v[0] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[1] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[2] = ev(4'd4, 11'b00000011000, 2'b00, 2'b00, 2'b00, ALUOp_ADD);
    exp_v[3] = ev(4'd6, 11'b00001100010, 2'b00, 2'b00, 2'b00, 5'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL sw cyc%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // beq zero=0, beq zero=1, bne zero=1: three back-to-back 3-cycle branches
  task automatic test_back_to_back_branches();
    logic [25:0] exp_v [9];
    logic [5:0]  op_v  [3];
    logic        z_v   [3];
    op_v[0] = OP_BEQ; z_v[0] = 1'b0;
    op_v[1] = OP_BEQ; z_v[1] = 1'b1;
    op_v[2] = OP_BNE; z_v[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_v[3*k]   = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
      exp_v[3*k+1] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);
    end
    exp_v[2] = ev(4'd8, 11'b00000000010, 2'b00, 2'b00, 2'b01, ALUOp_EQL);
    exp_v[5] = ev(4'd8, 11'b01000000010, 2'b00, 2'b00, 2'b01, ALUOp_EQL);
    exp_v[8] = ev(4'd8, 11'b01000000010, 2'b00, 2'b00, 2'b01, ALUOp_BNE);
    mem_ready = 1'b1; func = 6'h00;
    for (int i = 0; i < 9; i++) begin
      opcode = op_v[i/3]; zero = z_v[i/3];
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL branch cyc%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [25:0] exp_v [6];
    exp_v[0] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[1] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[2] = ev(4'd9, 11'b01100000010, 2'b10, 2'b10, 2'b10, 5'd0);
    exp_v[3] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[4] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[5] = ev(4'd9, 11'b01000000010, 2'b00, 2'b00, 2'b11, 5'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin opcode = OP_JAL;   func = 6'h00; end
      else       begin opcode = OP_RTYPE; func = FN_JR; end
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL jump cyc%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [25:0] exp_v [4];
    opcode = 6'h3F; func = 6'h00;
    exp_v[0] = ev(4'd0, 11'b00010000000, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[1] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[2] = ev(4'd1, 11'b00000000001, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[3] = ev(4'd0, 11'b00010000000, 2'b00, 2'b00, 2'b00, 5'd0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [25:0] exp_v [6];
    opcode = OP_SW; func = 6'h00;
    exp_v[0] = ev(4'd0, F_FETCH, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[1] = ev(4'd1, 11'd0, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[2] = ev(4'd4, 11'b00000011000, 2'b00, 2'b00, 2'b00, ALUOp_ADD);
    exp_v[3] = ev(4'd6, 11'b00001100000, 2'b00, 2'b00, 2'b00, 5'd0);
    exp_v[4] = 26'd0;
    exp_v[5] = ev(4'd0, 11'b00010000000, 2'b00, 2'b00, 2'b00, 5'd0);
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i < 3) ? 1'b1 : 1'b0;
      rst = (i == 4) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL rst_mid_wr cyc%0d: got %h expected %h", i, obs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = 6'h00; func = 6'h00;
    @(posedge clk); #1;
    test_reset();
    test_addu();
    test_sll_ori();
    test_lw_wait();
    test_sw();
    test_back_to_back_branches();
    test_jumps();
    test_illegal();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 opcode  in  6  instruction opcode from the external instruction register; valid from the DECODE state onward.
REQ-004 func  in  6  R-type function field from the instruction register.
REQ-005 zero  in  1  ALU compare result; 1 = branch condition true for ALUOp_EQL and for ALUOp_BNE.
REQ-006 mem_ready  in  1  memory handshake; 1 = access completes this cycle.
REQ-007 Outputs of width 1: IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IorD (0 = PC address, 1 = ALU-out address), ALUSrc, ExtOp, ShamtSrc, instr_done (1-cycle pulse), illegal (1-cycle pulse).
REQ-008 Outputs RegDst[1:0], DatatoReg[1:0] and PC_sel[1:0] carry the existing single-cycle encodings: 00 = seq/rt/ALU, 01 = branch/rd/mem, 10 = jump/$31/PC+4, 11 = jr.
REQ-009 ALUCtrl  out  5  carries the existing ALUOp encoding; state  out  4  is the current-state debug output.

Function
REQ-010 Moore FSM with states FETCH=0, DECODE=1, EXEC=2, WB=3, ADDR=4, MEM_RD=5, MEM_WR=6, LD_WB=7, BRANCH=8, JUMP=9; encodings 10-15 SHALL go to FETCH.
REQ-011 FETCH: MemRead=1, IorD=0.
REQ-012 FETCH: IRWrite=1 and PCWrite=1 (PC_sel=00) only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
REQ-013 DECODE: one cycle; latch the instruction class from opcode/func into a class register.
REQ-014 DECODE next state: R-ALU/shift/slt and addi/slti/ori/lui -> EXEC; lw/sw -> ADDR; beq/bne -> BRANCH; j/jal/jr -> JUMP.
REQ-015 DECODE, unsupported opcode or func: pulse illegal, go to FETCH, assert no write strobe.
REQ-016 EXEC: drive ALUCtrl, ALUSrc, ExtOp and ShamtSrc per instruction, identical to single-cycle decode (sll/srl/sra ShamtSrc=1; addi/slti ExtOp=1; ori/lui ExtOp=0), then go to WB.
REQ-017 WB: hold the EXEC ALU controls, RegWrite=1, RegDst=01 (R-type) or 00 (I-type), DatatoReg=00, instr_done=1, then go to FETCH.
REQ-018 ADDR: ALUSrc=1, ExtOp=1, ALUCtrl=ALUOp_ADD; next state MEM_RD (lw) or MEM_WR (sw).
REQ-019 MEM_RD: MemRead=1, IorD=1; stay until mem_ready=1, then go to LD_WB.
REQ-020 LD_WB: RegWrite=1, RegDst=00, DatatoReg=01, instr_done=1, then go to FETCH.
REQ-021 MEM_WR: MemWrite=1, IorD=1; stay until mem_ready=1, then instr_done=1 and go to FETCH.
REQ-022 BRANCH: ALUCtrl=ALUOp_EQL (beq) or ALUOp_BNE (bne), ALUSrc=0, PC_sel=01, PCWrite=zero, instr_done=1, then go to FETCH.
REQ-023 JUMP: PCWrite=1, instr_done=1, then go to FETCH; PC_sel=10 for j/jal and 11 for jr.
REQ-024 JUMP, jal only: additionally RegWrite=1, RegDst=10, DatatoReg=10.
REQ-025 Latency with mem_ready tied high: R/I-ALU 4 cycles, lw 5, sw 4, beq/bne 3, j/jal/jr 3; each mem_ready=0 cycle adds one cycle.
REQ-026 Every output not named for a state SHALL be 0 in that state.
REQ-027 At most one of RegWrite and MemWrite SHALL be high in any cycle.

Reset
REQ-028 While rst=1, all outputs SHALL be 0 and state is forced to FETCH on the next edge.
REQ-029 The class register SHALL clear on reset.
REQ-030 Reset mid-access (MEM_RD/MEM_WR/FETCH wait): abandon the access, no write strobe after rst is sampled; resume at FETCH after rst deasserts.

Structure
REQ-031 The shared package SHALL hold the state encodings, the instruction-class enumeration, and the existing ALUOp and opcode/func constants (reused, not redefined).
REQ-032 One sub-module, mc_decode, SHALL provide the combinational opcode/func -> class and ALUCtrl mapping; multicycle_ctrl holds all sequential logic.

Verification
REQ-033 addu (op 0x00, func 0x21), mem_ready=1 -> states 0,1,2,3; RegWrite=1 only in WB with RegDst=01; instr_done in cycle 4.
REQ-034 lw (op 0x23), mem_ready low 2 cycles in MEM_RD -> 7 cycles total; LD_WB has RegWrite=1, DatatoReg=01.
REQ-035 beq (op 0x04): zero=0 -> PCWrite stays 0 in BRANCH; zero=1 -> PCWrite=1 with PC_sel=01.
REQ-036 jal (op 0x03) -> 3 cycles; JUMP has PCWrite=1, PC_sel=10, RegWrite=1, RegDst=10, DatatoReg=10.
REQ-037 Opcode 0x3F -> illegal pulse in DECODE, next state FETCH, no write strobes.
REQ-038 rst=1 during MEM_WR with mem_ready=0 -> MemWrite=0 from the next cycle, state=0.
